// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller:
// the active-low hex glyph table, the blank pattern and the scan FSM states.
package seg_pkg;

    // Index = hex value, bits [6:0] = g..a, 0 = segment lit.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [6:0] SEG_OFF7  = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Host write port plus multiplexed display outputs of the scan controller.
// The host side uses the master modport; the controller uses slave.
interface seg_scan_ctrl_if #(
    parameter int NDIG = 8
);
    localparam int AW = $clog2(NDIG);

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [3:0]      wr_data;
    logic [NDIG-1:0] dp_mask;
    logic            lz_en;
    logic [7:0]      seg;
    logic [NDIG-1:0] an;
    logic [AW-1:0]   scan_idx;
    logic            frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, dp_mask, lz_en,
        input  seg, an, scan_idx, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, dp_mask, lz_en,
        output seg, an, scan_idx, frame_done
    );

endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// Hex-to-seven-segment decoder, active-low, shared by every digit slot.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    assign pattern = SEG_TABLE[value];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment controller: host-written digit registers,
// BLANK/SHOW scan FSM with per-slot latching and leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int DIV  = 1000,
    parameter int GAP  = 16
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int AW   = $clog2(NDIG);
    localparam int CMAX = (DIV > GAP) ? DIV : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    scan_state_t     state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [AW-1:0]   idx, idx_nx;
    logic [NDIG-1:0] an_q, an_nx;
    logic [7:0]      seg_q, seg_nx;
    logic            fd_q, fd_nx;
    logic [3:0]      regs [NDIG];
    logic [6:0]      pattern;
    logic            nonzero_above;
    logic            suppress;
    logic            wr_hit;

    assign wr_hit = bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NDIG));

    // Register file; reads at the latch edge see the value before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDIG; i++) begin
                regs[i] <= 4'd0;
            end
        end else if (wr_hit) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    seg_decode u_decode (
        .value   (regs[idx]),
        .pattern (pattern)
    );

    // Digit idx is blank-worthy only if it and every higher digit hold zero.
    always_comb begin
        nonzero_above = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if (j >= int'(idx) && regs[j] != 4'd0) begin
                nonzero_above = 1'b1;
            end
        end
        suppress = bus.lz_en && (idx != '0) && !nonzero_above;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= '0;
            an_q  <= '1;
            seg_q <= SEG_BLANK;
            fd_q  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            an_q  <= an_nx;
            seg_q <= seg_nx;
            fd_q  <= fd_nx;
        end
    end

    // Outputs are computed here as next values so they change with the state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        idx_nx   = idx;
        an_nx    = an_q;
        seg_nx   = seg_q;
        fd_nx    = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == CW'(GAP - 1)) begin
                    state_nx = SHOW;
                    cnt_nx   = '0;
                    an_nx    = ~(NDIG'(1) << idx);
                    seg_nx   = {~bus.dp_mask[idx], (suppress ? SEG_OFF7 : pattern)};
                end
            end
            SHOW: begin
                if (cnt == CW'(DIV - 1)) begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    an_nx    = '1;
                    seg_nx   = SEG_BLANK;
                    if (idx == AW'(NDIG - 1)) begin
                        idx_nx = '0;
                        fd_nx  = 1'b1;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = BLANK;
                cnt_nx   = '0;
            end
        endcase
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.scan_idx   = idx;
    assign bus.frame_done = fd_q;

endmodule
